nvdla_glb_csb_arb: RTL
======================

# nvdla_glb_csb_arb

Two-port CSB request arbiter that shares the single GLB register-slave port (`csb2glb_*` / `glb2csb_*`) between a host requester (A) and a firmware/debug requester (B). It issues requests round-robin and tracks response-expecting requests in order, so each response goes back to the requester that issued it. It sits between the CSB fabric and the GLB CSB slave in the GLB partition.

## Interface
Parameters:
- `DEPTH`, 4: outstanding response-expecting requests tracked (power of two, 2..16).
- `TMO_CYC`, 1023: timeout limit in cycles; used only with the timeout feature.

Ports:
- `nvdla_core_clk`  in  1  core clock; the only clock.
- `nvdla_core_rst`  in  1  reset; synchronous, active-high.
- `a_req_pvld` / `b_req_pvld`  in  1  requester valid.
- `a_req_pd` / `b_req_pd`  in  63  request payload: [62:61] level, [60:57] wrbe, [56] srcpriv, [55] nposted, [54] write, [53:22] wdat, [21:0] addr.
- `a_req_prdy` / `b_req_prdy`  out  1  requester ready.
- `csb2glb_req_pvld`  out  1  valid toward the slave.
- `csb2glb_req_pd`  out  63  payload toward the slave.
- `csb2glb_req_prdy`  in  1  slave ready.
- `glb2csb_resp_valid`  in  1  slave response valid; cannot be backpressured.
- `glb2csb_resp_pd`  in  34  response: [33] write-ack, [32] error, [31:0] rdata.
- `a_resp_valid` / `b_resp_valid`  out  1  routed response valid.
- `a_resp_pd` / `b_resp_pd`  out  34  routed response payload.
- `stray_resp`  out  1  sticky flag: a response arrived with nothing outstanding.
- `outstanding`  out  $clog2(DEPTH)+1  tracking FIFO occupancy.

## Operation
- A request needs a response when `!write | nposted`. Posted writes need no response.
- Output stage: one register (`csb2glb_req_pvld/pd`). It is free when empty, or when `csb2glb_req_prdy` is high in the current cycle.
- Eligibility: requester X is eligible when `X_req_pvld` is high, the output stage is free, and either the request needs no response or `outstanding < DEPTH`. The same-cycle FIFO pop is not counted toward this check.
- Round-robin arbitration:
  - `last` pointer; 0 = A granted last, 1 = B granted last. Reset value is 1, so A wins the first tie.
  - If both are eligible, the one not equal to `last` wins. If only one is eligible, it wins.
  - `last` updates on every grant.
  - `X_req_prdy` equals the grant to X and is combinational from the inputs and state.
- On grant: the payload loads into the output stage. If the request needs a response, the requester ID (0 = A, 1 = B) is pushed into the tracking FIFO.
- Response routing:
  - On `glb2csb_resp_valid`, the FIFO head is popped. The response is registered to the matching `X_resp_valid/pd` on the next cycle.
  - The non-selected `resp_valid` output is 0.
  - If the FIFO is empty, the response is dropped and `stray_resp` is set. Only reset clears it.
- The FIFO supports a push and a pop in the same cycle; occupancy is then unchanged.

## Timing
- Reset values: `csb2glb_req_pvld`=0, `a/b_resp_valid`=0, `stray_resp`=0, `outstanding`=0, `last`=1. Payload registers hold X (no reset).
- Request latency: grant in cycle N gives `csb2glb_req_pvld` in cycle N+1.
- Throughput: one request per cycle while `csb2glb_req_prdy` stays high.
- Holding: while `csb2glb_req_pvld=1 & csb2glb_req_prdy=0`, the output payload is held and no grant is issued.
- Response latency: `glb2csb_resp_valid` in cycle M gives `X_resp_valid` in cycle M+1, a single-cycle pulse.
- Reset during operation: the FIFO, output stage and flags clear within one cycle. Responses arriving later count as stray.

## Configuration
- Macro `NVDLA_GLB_CSB_ARB_TIMEOUT_EN`.
- Defined:
  - A 10+ bit counter runs while `outstanding != 0 & !glb2csb_resp_valid`. It clears on any response or pop.
  - When the counter reaches `TMO_CYC`, the arbiter pops the FIFO head. It sends the owner a synthetic response one cycle later: [33]=0, [32]=1, [31:0]=0.
  - If a real response and the timeout occur in the same cycle, the real response wins.
- Undefined: no counter exists, and the arbiter waits indefinitely for responses.

## Test plan
- A reads addr 0x004 while B is idle. `csb2glb_req_pvld` rises one cycle after grant; slave returns rdata 0xDEADBEEF. Required: `a_resp_valid` pulses with pd = {0,0,0xDEADBEEF}; `b_resp_valid` stays 0.
- A and B both hold valid reads for 4 cycles with the slave always ready. Required: grant order A,B,A,B; responses return to the owners in the same order.
- B issues 6 back-to-back non-posted writes with DEPTH=4 and no responses. Required: `b_req_prdy` drops after the 4th grant and `outstanding`=4; a posted write from A is still granted.
- Slave holds `csb2glb_req_prdy`=0 for 3 cycles. Required: output pd stays stable, both `req_prdy` signals stay 0, and the request drains on the 4th cycle.
- Response arrives with `outstanding`=0. Required: no `resp_valid` pulse; `stray_resp`=1 until reset.
- With the timeout feature defined and TMO_CYC=8, issue a read and give no response. Required: the owner receives pd bit 32 = 1 nine cycles after issue, and `outstanding` returns to 0.

Source files
------------

// File: rtl/nvdla_glb_csb_arb.sv
// nvdla_glb_csb_arb
//
// Shares the single GLB CSB register-slave port between a host requester (A) and a
// firmware/debug requester (B). Requests are granted round-robin into a one-entry
// output register. The owner of every response-expecting request is recorded in an
// in-order tracking FIFO, so each slave response is routed back to its issuer.
//
// Optional feature: define NVDLA_GLB_CSB_ARB_TIMEOUT_EN to add a response timeout.
// When a response is overdue by TMO_CYC cycles, the oldest outstanding request is
// retired with a synthetic error response.
//
// Ports
//   nvdla_core_clk, nvdla_core_rst     clock and synchronous active-high reset
//   a_req_* / b_req_*                  requester valid/ready/payload (63 bits)
//   csb2glb_req_*                      request channel toward the GLB slave
//   glb2csb_resp_valid/pd              slave response (34 bits, no backpressure)
//   a_resp_* / b_resp_*                routed responses, single-cycle pulses
//   stray_resp                         sticky: response arrived with nothing outstanding
//   outstanding                        tracking FIFO occupancy
module nvdla_glb_csb_arb #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic                       a_req_pvld,
    input  logic [62:0]                a_req_pd,
    output logic                       a_req_prdy,
    input  logic                       b_req_pvld,
    input  logic [62:0]                b_req_pd,
    output logic                       b_req_prdy,
    output logic                       csb2glb_req_pvld,
    output logic [62:0]                csb2glb_req_pd,
    input  logic                       csb2glb_req_prdy,
    input  logic                       glb2csb_resp_valid,
    input  logic [33:0]                glb2csb_resp_pd,
    output logic                       a_resp_valid,
    output logic [33:0]                a_resp_pd,
    output logic                       b_resp_valid,
    output logic [33:0]                b_resp_pd,
    output logic                       stray_resp,
    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic          out_vld_q;
    logic [62:0]   out_pd_q;
    logic          last_q;
    logic          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          a_resp_valid_q, b_resp_valid_q;
    logic [33:0]   resp_pd_q;
    logic          stray_q;

    logic a_need, b_need, fifo_room, stage_free;
    logic a_elig, b_elig, gnt_a, gnt_b, gnt;
    logic push, pop, real_pop, tmo_pop, fifo_empty, head;

    // Reads and non-posted writes expect a response.
    assign a_need     = !a_req_pd[54] | a_req_pd[55];
    assign b_need     = !b_req_pd[54] | b_req_pd[55];
    assign fifo_room  = count_q < DepthC;
    assign stage_free = !out_vld_q | csb2glb_req_prdy;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        a_elig = a_req_pvld & stage_free & (!a_need | fifo_room);
        b_elig = b_req_pvld & stage_free & (!b_need | fifo_room);
        // On a tie, the requester not granted last wins.
        gnt_a  = a_elig & (!b_elig | last_q);
        gnt_b  = b_elig & (!a_elig | !last_q);
        gnt    = gnt_a | gnt_b;
        push   = (gnt_a & a_need) | (gnt_b & b_need);
    end

    assign real_pop = glb2csb_resp_valid & !fifo_empty;
    assign pop      = real_pop | tmo_pop;

`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TMO_CYC + 1) > 10) ? $clog2(TMO_CYC + 1) : 10;
    logic [TW-1:0] tmo_cnt_q;

    // A real response in the same cycle takes precedence over the timeout.
    assign tmo_pop = !fifo_empty & !glb2csb_resp_valid & (tmo_cnt_q == TW'(TMO_CYC));

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || fifo_empty || glb2csb_resp_valid || pop) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_pop = 1'b0;
`endif

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            out_vld_q      <= 1'b0;
            last_q         <= 1'b1;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            a_resp_valid_q <= 1'b0;
            b_resp_valid_q <= 1'b0;
            stray_q        <= 1'b0;
        end else begin
            if (stage_free) out_vld_q <= gnt;
            if (gnt)        last_q    <= gnt_b;
            if (push)       wr_ptr_q  <= wr_ptr_q + 1'b1;
            if (pop)        rd_ptr_q  <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            a_resp_valid_q <= pop & !head;
            b_resp_valid_q <= pop & head;
            if (glb2csb_resp_valid && fifo_empty) stray_q <= 1'b1;
        end
    end

    // Payload and FIFO storage carry no reset; validity is tracked separately.
    always_ff @(posedge nvdla_core_clk) begin
        if (gnt)  out_pd_q         <= gnt_a ? a_req_pd : b_req_pd;
        if (push) mem_q[wr_ptr_q]  <= gnt_b;
        if (pop)  resp_pd_q        <= real_pop ? glb2csb_resp_pd : {1'b0, 1'b1, 32'h0};
    end

    assign a_req_prdy       = gnt_a;
    assign b_req_prdy       = gnt_b;
    assign csb2glb_req_pvld = out_vld_q;
    assign csb2glb_req_pd   = out_pd_q;
    assign a_resp_valid     = a_resp_valid_q;
    assign b_resp_valid     = b_resp_valid_q;
    assign a_resp_pd        = resp_pd_q;
    assign b_resp_pd        = resp_pd_q;
    assign stray_resp       = stray_q;
    assign outstanding      = count_q;

endmodule
